// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared definitions for single-digit BCD counting blocks: digit width,
//   count limits, direction encodings and a digit validity helper.
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int unsigned      BCD_DIGIT_W = 4;
  localparam logic [3:0]       BCD_MIN     = 4'd0;
  localparam logic [3:0]       BCD_MAX     = 4'd9;

  localparam logic             DIR_UP      = 1'b1;
  localparam logic             DIR_DOWN    = 1'b0;

  // BCD_MIN is zero, so only the upper bound needs testing for an unsigned digit.
  function automatic logic is_bcd_valid(input logic [BCD_DIGIT_W-1:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_step.sv
// -----------------------------------------------------------------------------
// bcd_digit_step
//   Combinational next-value logic for one BCD digit.
//   Ports:
//     cur  in   4  current digit value
//     dir  in   1  count direction (DIR_UP / DIR_DOWN)
//     nxt  out  4  digit value after one step
//     wrap out  1  high when the step wraps 9->0 (up) or 0->9 (down)
//   Illegal codes (A-F) step to BCD_MIN in either direction and do not wrap.
//   Wrap is decided by equality with the limits before any add/subtract, so
//   the 4-bit arithmetic never relies on modular carry.
// -----------------------------------------------------------------------------
module bcd_digit_step
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] cur,
  input  logic                   dir,
  output logic [BCD_DIGIT_W-1:0] nxt,
  output logic                   wrap
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    nxt  = BCD_MIN;
    wrap = 1'b0;
    if (!is_bcd_valid(cur)) begin
      nxt = BCD_MIN;
    end else if (dir == DIR_UP) begin
      if (cur == BCD_MAX) begin
        nxt  = BCD_MIN;
        wrap = 1'b1;
      end else begin
        nxt = cur + 4'd1;
      end
    end else begin
      if (cur == BCD_MIN) begin
        nxt  = BCD_MAX;
        wrap = 1'b1;
      end else begin
        nxt = cur - 4'd1;
      end
    end
  end

endmodule : bcd_digit_step

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//   Single-digit BCD up/down counter, one step per rising clock edge, wrapping
//   at both ends. Leaf digit for display/timing chains.
//   Ports:
//     clk  in   1  clock, all state changes on its rising edge
//     rst  in   1  synchronous active-low reset, forces q to BCD_MIN
//     sel  in   1  direction: 1 = up, 0 = down (ignored during reset)
//     q    out  4  current BCD digit, straight from the count register
// -----------------------------------------------------------------------------
module bcd_updown_counter
  import bcd_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel,
  output logic [BCD_DIGIT_W-1:0] q
);

  logic [BCD_DIGIT_W-1:0] count_q;
  logic [BCD_DIGIT_W-1:0] count_d;
  logic [BCD_DIGIT_W-1:0] step_nxt;
  // Wrap flag is kept for a future carry into the next digit of a chain.
  logic                   unused_wrap;

  bcd_digit_step u_step (
    .cur  (count_q),
    .dir  (sel),
    .nxt  (step_nxt),
    .wrap (unused_wrap)
  );

  always_comb begin
    count_d = step_nxt;
  end

  // NOTE: reset is synchronous (inside the clocked branch, not in the
  // sensitivity list) and wins over counting; state uses non-blocking <=.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= BCD_MIN;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule : bcd_updown_counter

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
//   Scoreboard bench: the driver applies rst/sel on the falling edge and pushes
//   the value q must show after the next rising edge; an independent monitor
//   pops one entry per rising edge and compares.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

  logic       clk;
  logic       rst;
  logic       sel;
  logic [3:0] q;

  bcd_updown_counter dut (
    .clk (clk),
    .rst (rst),
    .sel (sel),
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] exp;
    logic       chk_step;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int checks = 0;
  int errors = 0;

  logic [3:0] model;  // reference value after the most recently driven edge

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one edge with a hand-computed expectation.
  task automatic drive(input logic rst_v, input logic sel_v,
                       input logic [3:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    rst = rst_v;
    sel = sel_v;
    e.exp      = exp;
    e.chk_step = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(name);
    model = exp;
  endtask

  // Drive one edge with the expectation taken from the reference model.
  task automatic drive_model(input logic rst_v, input logic sel_v);
    exp_t e;
    @(negedge clk);
    rst = rst_v;
    sel = sel_v;
    if (!rst_v)     model = 4'd0;
    else if (sel_v) model = (model == 4'd9) ? 4'd0 : model + 4'd1;
    else            model = (model == 4'd0) ? 4'd9 : model - 4'd1;
    e.exp      = model;
    e.chk_step = 1'b1;
    exp_q.push_back(e);
    name_q.push_back("sweep");
  endtask

  // Monitor: one output per rising edge.
  logic [3:0] prev_q;
  initial begin
    prev_q = 4'hx;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t  e;
        string n;
        logic  legal;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, q, e.exp);
        if (e.chk_step) begin
          check("sweep_range", {3'b000, (q <= 4'd9)}, 4'd1);
          legal = (q == 4'd0) ||                      // reset or up-wrap
                  (q == prev_q + 4'd1) ||
                  (q == prev_q - 4'd1) ||
                  (prev_q == 4'd0 && q == 4'd9);
          check("sweep_step", {3'b000, legal}, 4'd1);
        end
      end
      prev_q = q;
    end
  end

  initial begin
    logic [3:0] up_seq[12];
    logic [3:0] dn_seq[12];
    int         budget;

    up_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    dn_seq = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    rst   = 1'b1;
    sel   = 1'b1;
    model = 4'hx;

    // Reset with sel undriven, then held for five edges.
    drive(1'b0, 1'bx, 4'd0, "reset_sel_x");
    for (int i = 0; i < 5; i++) drive(1'b0, i[0], 4'd0, "reset_hold");

    // Up wrap.
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, up_seq[i], "up_wrap");
    drive(1'b0, 1'b1, 4'd0, "reset_between");

    // Down wrap from reset.
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, dn_seq[i], "down_wrap");
    drive(1'b0, 1'b0, 4'd0, "reset_between");

    // Direction change: up to 5, down to 3, up to 4.
    for (int i = 1; i <= 5; i++) drive(1'b1, 1'b1, 4'(i), "dir_up_to5");
    drive(1'b1, 1'b0, 4'd4, "dir_down_4");
    drive(1'b1, 1'b0, 4'd3, "dir_down_3");
    drive(1'b1, 1'b1, 4'd4, "dir_up_4");

    // Reset mid-count at 7, then release counting down.
    drive(1'b0, 1'b1, 4'd0, "reset_before_mid");
    for (int i = 1; i <= 7; i++) drive(1'b1, 1'b1, 4'(i), "mid_up_to7");
    drive(1'b0, 1'b1, 4'd0, "mid_reset");
    drive(1'b1, 1'b0, 4'd9, "release_down");

    // Random sweep against the reference model.
    for (int i = 0; i < 200; i++) begin
      drive_model(($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)));
    end

    // Let the monitor drain, bounded.
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bcd_updown_counter
